// File: rtl/iecdrv_fastser_pkg.sv
// rtl/iecdrv_fastser_pkg.sv - shared types and constants for the fast-serial link
package iecdrv_fastser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } fs_state_e;

    localparam int FS_BITS            = 8;
    localparam int FS_HALF_PERIOD_DEF = 4;
    localparam int FS_RX_TIMEOUT_DEF  = 64;

endpackage

// File: rtl/iecdrv_fastser_edge.sv
// rtl/iecdrv_fastser_edge.sv - cnt_in register and rising-edge detect
module iecdrv_fastser_edge (
    input  logic clk,
    input  logic reset,
    input  logic cnt_in,
    output logic rise
);

    logic cnt_q, cnt_d;
    logic prev_q, prev_d;

    always_comb begin
        cnt_d  = cnt_in;
        prev_d = cnt_q;
    end

    // Both stages reset high to match the idle bus, so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end

    assign rise = cnt_q & ~prev_q;

endmodule

// File: rtl/iecdrv_fastser_link.sv
// rtl/iecdrv_fastser_link.sv - SP/CNT fast-serial partner; FASTSER_RX_TIMEOUT_EN adds RX idle timeout
module iecdrv_fastser_link
    import iecdrv_fastser_pkg::*;
#(
    parameter int HALF_PERIOD = FS_HALF_PERIOD_DEF
`ifdef FASTSER_RX_TIMEOUT_EN
    , parameter int RX_TIMEOUT = FS_RX_TIMEOUT_DEF
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         phi2_p,
    input  logic         dir,
    input  logic         tx_valid,
    input  logic [7:0]   tx_data,
    output logic         tx_ready,
    output logic         tx_done,
    output logic         rx_valid,
    output logic [7:0]   rx_data,
    output logic         rx_err,
    output logic         busy,
    input  logic         sp_in,
    output logic         sp_out,
    input  logic         cnt_in,
    output logic         cnt_out
);

    localparam logic [7:0] HP_M1    = 8'(HALF_PERIOD - 1);
    localparam logic [2:0] LAST_BIT = 3'(FS_BITS - 1);

    fs_state_e          state_q, state_d;
    logic [FS_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]         tx_bitcnt_q, tx_bitcnt_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic               sp_out_q, sp_out_d;
    logic               cnt_out_q, cnt_out_d;
    logic               tx_done_q, tx_done_d;
    logic               run_q, run_d;

    logic [FS_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic [2:0]         rx_bitcnt_q, rx_bitcnt_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               cnt_rise;
    logic               half_end;

    iecdrv_fastser_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .cnt_in (cnt_in),
        .rise   (cnt_rise)
    );

    assign half_end = phi2_p && (hcnt_q == HP_M1);
    // run_q keeps tx_ready low for the first clk after reset release.
    assign run_d    = 1'b1;
    assign tx_ready = dir && run_q && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        tx_bitcnt_d = tx_bitcnt_q;
        hcnt_d      = hcnt_q;
        sp_out_d    = sp_out_q;
        cnt_out_d   = cnt_out_q;
        tx_done_d   = 1'b0;
        if (!dir) begin
            state_d   = ST_IDLE;
            sp_out_d  = 1'b1;
            cnt_out_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg_d     = tx_data;
                        tx_bitcnt_d = 3'd0;
                        hcnt_d      = 8'd0;
                        sp_out_d    = tx_data[FS_BITS-1];
                        cnt_out_d   = 1'b0;
                        state_d     = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (half_end) begin
                        hcnt_d    = 8'd0;
                        cnt_out_d = 1'b1;
                        state_d   = ST_HIGH;
                    end else if (phi2_p) begin
                        hcnt_d = hcnt_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (half_end) begin
                        hcnt_d      = 8'd0;
                        shreg_d     = {shreg_q[FS_BITS-2:0], 1'b0};
                        tx_bitcnt_d = tx_bitcnt_q + 3'd1;
                        if (tx_bitcnt_q == LAST_BIT) begin
                            tx_done_d = 1'b1;
                            sp_out_d  = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            sp_out_d  = shreg_q[FS_BITS-2];
                            cnt_out_d = 1'b0;
                            state_d   = ST_LOW;
                        end
                    end else if (phi2_p) begin
                        hcnt_d = hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    sp_out_d  = 1'b1;
                    cnt_out_d = 1'b1;
                end
            endcase
        end
    end

`ifdef FASTSER_RX_TIMEOUT_EN
    localparam logic [15:0] TO_M1 = 16'(RX_TIMEOUT - 1);
    logic [15:0] idle_q, idle_d;
    logic        rx_err_q, rx_err_d;
`endif

    always_comb begin
        rx_shreg_d  = rx_shreg_q;
        rx_bitcnt_d = rx_bitcnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
`ifdef FASTSER_RX_TIMEOUT_EN
        idle_d      = idle_q;
        rx_err_d    = 1'b0;
`endif
        if (dir) begin
            rx_bitcnt_d = 3'd0;
`ifdef FASTSER_RX_TIMEOUT_EN
            idle_d      = 16'd0;
`endif
        end else if (cnt_rise) begin
            // An edge outranks a timeout landing in the same clk.
            rx_shreg_d = {rx_shreg_q[FS_BITS-2:0], sp_in};
            if (rx_bitcnt_q == LAST_BIT) begin
                rx_data_d   = {rx_shreg_q[FS_BITS-2:0], sp_in};
                rx_valid_d  = 1'b1;
                rx_bitcnt_d = 3'd0;
            end else begin
                rx_bitcnt_d = rx_bitcnt_q + 3'd1;
            end
`ifdef FASTSER_RX_TIMEOUT_EN
            idle_d = 16'd0;
        end else if (rx_bitcnt_q == 3'd0) begin
            idle_d = 16'd0;
        end else if (phi2_p) begin
            if (idle_q == TO_M1) begin
                idle_d      = 16'd0;
                rx_bitcnt_d = 3'd0;
                rx_err_d    = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            tx_bitcnt_q <= 3'd0;
            hcnt_q      <= 8'd0;
            sp_out_q    <= 1'b1;
            cnt_out_q   <= 1'b1;
            tx_done_q   <= 1'b0;
            run_q       <= 1'b0;
            rx_shreg_q  <= '0;
            rx_bitcnt_q <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
`ifdef FASTSER_RX_TIMEOUT_EN
            idle_q      <= 16'd0;
            rx_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            tx_bitcnt_q <= tx_bitcnt_d;
            hcnt_q      <= hcnt_d;
            sp_out_q    <= sp_out_d;
            cnt_out_q   <= cnt_out_d;
            tx_done_q   <= tx_done_d;
            run_q       <= run_d;
            rx_shreg_q  <= rx_shreg_d;
            rx_bitcnt_q <= rx_bitcnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
`ifdef FASTSER_RX_TIMEOUT_EN
            idle_q      <= idle_d;
            rx_err_q    <= rx_err_d;
`endif
        end
    end

`ifdef FASTSER_RX_TIMEOUT_EN
    assign rx_err = rx_err_q;
`else
    assign rx_err = 1'b0;
`endif

    assign tx_done  = tx_done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sp_out   = sp_out_q;
    assign cnt_out  = cnt_out_q;
    assign busy     = (state_q != ST_IDLE) || (rx_bitcnt_q != 3'd0);

endmodule

// File: tb/tb_iecdrv_fastser_link.sv
// tb/tb_iecdrv_fastser_link.sv - self-checking bench for iecdrv_fastser_link
module tb_iecdrv_fastser_link;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       phi2_p = 1'b0;
    logic       dir = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, rx_valid, rx_err, busy;
    logic [7:0] rx_data;
    logic       sp_in = 1'b1;
    logic       sp_out;
    logic       cnt_in = 1'b1;
    logic       cnt_out;

    int checks = 0;
    int errors = 0;

    int   tx_done_cnt = 0;
    int   rx_valid_cnt = 0;
    int   rx_err_cnt = 0;
    int   busy_ticks = 0;
    logic [7:0] rx_last = 8'h00;
    logic [7:0] rx_model = 8'h00;
    int   lo_q[$];
    int   hi_q[$];
    bit   bits_q[$];
    int   low_ticks = 0;
    int   high_ticks = 0;
    logic prev_cnt = 1'b1;

    iecdrv_fastser_link dut (
        .clk      (clk),
        .reset    (reset),
        .phi2_p   (phi2_p),
        .dir      (dir),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .busy     (busy),
        .sp_in    (sp_in),
        .sp_out   (sp_out),
        .cnt_in   (cnt_in),
        .cnt_out  (cnt_out)
    );

    initial forever #5 clk = ~clk;

    // One phi2 tick every fourth clk.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            phi2_p = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // Bus observer: pulse widths in phi2 ticks, data at each CNT rise, event counts.
    always @(negedge clk) begin
        if (prev_cnt && !cnt_out) begin
            hi_q.push_back(high_ticks);
            low_ticks = 0;
        end
        if (!prev_cnt && cnt_out) begin
            lo_q.push_back(low_ticks);
            bits_q.push_back(sp_out);
            high_ticks = 0;
        end
        if (phi2_p) begin
            if (!cnt_out) low_ticks++;
            else high_ticks++;
            if (busy) busy_ticks++;
        end
        prev_cnt = cnt_out;
        if (tx_done) tx_done_cnt++;
        if (rx_err) rx_err_cnt++;
        if (rx_valid) begin
            rx_valid_cnt++;
            rx_last = rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        lo_q.delete();
        hi_q.delete();
        bits_q.delete();
        busy_ticks = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (tx_done_cnt < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t0;
        int bad;
        logic [7:0] got;
        dir = 1'b1;
        clear_mon();
        t0 = tx_done_cnt;
        wait_ready();
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(t0 + 1);
        got = 8'h00;
        foreach (bits_q[i]) got = {got[6:0], bits_q[i]};
        bad = 0;
        foreach (lo_q[i]) if (lo_q[i] != HP) bad++;
        for (int i = 1; i < hi_q.size(); i++) if (hi_q[i] != HP) bad++;
        chk("tx_bits", {24'd0, got}, {24'd0, b});
        chk("tx_pulses", lo_q.size(), 8);
        chk("tx_widths", bad, 0);
        chk("tx_byte_ticks", busy_ticks, 16 * HP);
        chk("tx_done_once", tx_done_cnt - t0, 1);
        chk("tx_idle_lines", {30'd0, sp_out, cnt_out}, 32'd3);
    endtask

    task automatic rx_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sp_in = b[i];
            cnt_in = 1'b0;
            repeat (4) @(negedge clk);
            cnt_in = 1'b1;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        int v0;
        v0 = rx_valid_cnt;
        dir = 1'b0;
        rx_bits(b, 8);
        rx_model = b;
        chk("rx_valid_once", rx_valid_cnt - v0, 1);
        chk("rx_valid_data", {24'd0, rx_last}, {24'd0, rx_model});
        chk("rx_data", {24'd0, rx_data}, {24'd0, rx_model});
        chk("rx_busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t0;
        int v0;
        int e0;
        int n;
        int bad;
        logic [7:0] got;
        logic [15:0] pair;

        repeat (3) @(negedge clk);
        chk("rst_sp_out", {31'd0, sp_out}, 32'd1);
        chk("rst_cnt_out", {31'd0, cnt_out}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tx_ready_after_rst", {31'd0, tx_ready}, 32'd1);

        send_byte(8'hA5);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));

        // Back-to-back: valid held high, data switched once the first byte is taken.
        clear_mon();
        t0 = tx_done_cnt;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        tx_data = 8'hC3;
        n = 0;
        while (!tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_with_done", {31'd0, tx_done}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(t0 + 2);
        pair = 16'h0000;
        foreach (bits_q[i]) pair = {pair[14:0], bits_q[i]};
        bad = 0;
        foreach (lo_q[i]) if (lo_q[i] != HP) bad++;
        for (int i = 1; i < hi_q.size(); i++) if (hi_q[i] != HP) bad++;
        chk("b2b_bits", {16'd0, pair}, 32'h3CC3);
        chk("b2b_pulses", lo_q.size(), 16);
        chk("b2b_no_gap", bad, 0);
        chk("b2b_done_cnt", tx_done_cnt - t0, 2);

        rx_byte(8'h96);
        for (int k = 0; k < 2; k++) rx_byte(8'($urandom));

        // Partial RX byte aborted by a direction change.
        v0 = rx_valid_cnt;
        e0 = rx_err_cnt;
        rx_bits(8'hE0, 3);
        chk("rx_partial_busy", {31'd0, busy}, 32'd1);
        dir = 1'b1;
        repeat (2) @(negedge clk);
        dir = 1'b0;
        @(negedge clk);
        chk("rx_abort_busy", {31'd0, busy}, 32'd0);
        chk("rx_abort_no_valid", rx_valid_cnt - v0, 0);
        chk("rx_abort_no_err", rx_err_cnt - e0, 0);
        chk("rx_abort_data", {24'd0, rx_data}, {24'd0, rx_model});

        // Partial RX byte left to stall.
        e0 = rx_err_cnt;
        v0 = rx_valid_cnt;
        rx_bits(8'hE0, 3);
        repeat (200) @(negedge clk);
        chk("rx_stall_no_err_yet", rx_err_cnt - e0, 0);
        chk("rx_stall_busy", {31'd0, busy}, 32'd1);
        repeat (120) @(negedge clk);
`ifdef FASTSER_RX_TIMEOUT_EN
        chk("rx_timeout_err", rx_err_cnt - e0, 1);
        chk("rx_timeout_busy", {31'd0, busy}, 32'd0);
`else
        chk("rx_no_timeout_err", rx_err_cnt - e0, 0);
        chk("rx_no_timeout_busy", {31'd0, busy}, 32'd1);
        dir = 1'b1;
        repeat (2) @(negedge clk);
        dir = 1'b0;
        @(negedge clk);
`endif
        chk("rx_stall_data_kept", {24'd0, rx_data}, {24'd0, rx_model});
        chk("rx_stall_no_valid", rx_valid_cnt - v0, 0);
        rx_byte(8'h5A);

        // Direction flip in the LOW phase of bit 3.
        dir = 1'b1;
        clear_mon();
        t0 = tx_done_cnt;
        wait_ready();
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(bits_q.size() >= 3 && !cnt_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit3", bits_q.size(), 3);
        dir = 1'b0;
        @(negedge clk);
        chk("abort_cnt_out", {31'd0, cnt_out}, 32'd1);
        chk("abort_sp_out", {31'd0, sp_out}, 32'd1);
        chk("abort_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (200) @(negedge clk);
        chk("abort_no_done", tx_done_cnt - t0, 0);

        // Asynchronous reset during a LOW phase.
        dir = 1'b1;
        clear_mon();
        t0 = tx_done_cnt;
        wait_ready();
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(bits_q.size() >= 2 && !cnt_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_low_phase", {31'd0, cnt_out}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_cnt_out", {31'd0, cnt_out}, 32'd1);
        chk("rst_mid_sp_out", {31'd0, sp_out}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_ready_after", {31'd0, tx_ready}, 32'd1);
        repeat (100) @(negedge clk);
        chk("rst_mid_no_done", tx_done_cnt - t0, 0);
        chk("rst_mid_cnt_idle", {31'd0, cnt_out}, 32'd1);

        send_byte(8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
